uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter clk_frequence, default 5_000_000, clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, line baud rate, used only for the timeout.
REQ-003 Parameter HEADER, default 8'hA5, start-of-frame byte.
REQ-004 Parameter MAX_LEN, default 16, maximum payload length in bytes.
REQ-005 Parameter TIMEOUT_BYTES, default 3, inter-byte timeout measured in 10-bit character times.
REQ-006 Port clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst_n  input  1  reset, synchronous and active-low.
REQ-008 Port pi_data  input  8  received byte from the UART receiver.
REQ-009 Port pi_flag  input  1  byte-valid strobe; each high cycle SHALL count as one byte.
REQ-010 Port po_data  output  8  payload byte.
REQ-011 Port po_flag  output  1  one-cycle payload-byte-valid strobe.
REQ-012 Port po_len  output  8  accepted frame length, valid while frame_ok is high.
REQ-013 Port frame_ok  output  1  one-cycle pulse: frame complete and checksum matched.
REQ-014 Port frame_err  output  1  one-cycle pulse: bad length, checksum mismatch or timeout.
REQ-015 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The block SHALL implement a four-state FSM: IDLE, LEN, PAYLOAD, CHK.
REQ-017 IDLE: on a byte equal to HEADER, the FSM SHALL go to LEN; any other byte SHALL be dropped silently, with no error.
REQ-018 LEN: a byte L of 0 or greater than MAX_LEN SHALL pulse frame_err and return the FSM to IDLE.
REQ-019 LEN: any other L SHALL be stored, SHALL load sum=L and count=0, and SHALL move the FSM to PAYLOAD.
REQ-020 PAYLOAD: each byte SHALL produce po_data=byte and po_flag=1, sum=(sum+byte) mod 256 and count+1; when count reaches L the FSM SHALL go to CHK.
REQ-021 CHK: a byte equal to sum SHALL pulse frame_ok with po_len=L; any other byte SHALL pulse frame_err; both cases SHALL return the FSM to IDLE.
REQ-022 HEADER-valued bytes in LEN, PAYLOAD or CHK SHALL be treated as ordinary data.
REQ-023 All outputs SHALL be registered, with latency exactly 1 cycle from the pi_flag cycle.
REQ-024 po_data SHALL hold its last value between strobes.
REQ-025 Payload already emitted SHALL NOT be retracted; the consumer discards a frame on frame_err.
REQ-026 The timeout counter SHALL clear on every pi_flag and in IDLE, and SHALL increment otherwise.
REQ-027 The timeout limit SHALL be TIMEOUT_BYTES*10*(clk_frequence/baud_rate) cycles, with counter width set by $clog2.
REQ-028 When the counter reaches the limit, the block SHALL pulse frame_err, return to IDLE and clear the counter.
REQ-029 If pi_flag coincides with the timeout terminal count, the byte SHALL win: it is processed and no timeout occurs.
REQ-030 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-031 A new HEADER byte SHALL be accepted in the cycle immediately after the FSM returns to IDLE.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL set state=IDLE.
REQ-033 While rst_n=0 at a clock edge, po_data, po_len, sum, count and the timeout counter SHALL be 0.
REQ-034 While rst_n=0 at a clock edge, po_flag, frame_ok, frame_err and busy SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame without pulsing frame_err.
REQ-036 pi_flag SHALL be ignored during reset.

Structure
REQ-037 The shared package uart_pkg SHALL hold the state encodings, the HEADER default and the cnt_baud_max = clk_frequence/baud_rate computation shared with the receiver.
REQ-038 The timeout SHALL be one sub-module, uart_timeout_cnt (ports: clear, enable, expired); the FSM and datapath SHALL remain in uart_frame_parser.

Verification
REQ-039 Good frame: bytes A5 03 11 22 33 69 -> po_flag three times with po_data 11, 22, 33, then frame_ok with po_len=03, and no frame_err.
REQ-040 Bad checksum: bytes A5 03 11 22 33 68 -> three payload strobes, then frame_err; frame_ok stays 0.
REQ-041 Resync: bytes 00 FF A5 00 -> no output for 00 FF; frame_err on the length byte 00.
REQ-042 Resync, follow-on: after REQ-041, A5 01 7E 7F -> frame_ok with po_len=01.
REQ-043 Bad length: bytes A5 11 (17 > MAX_LEN) -> frame_err; busy low 1 cycle later.
REQ-044 Timeout (defaults, limit 3*10*520 = 15600 cycles): bytes A5 03 11 then idle -> frame_err exactly 15600 cycles after the 11 strobe.
REQ-045 Timeout boundary: a byte arriving on the terminal cycle of REQ-044 -> no frame_err.
REQ-046 Reset mid-frame: bytes A5 03 11, then rst_n=0 for 2 cycles -> all outputs 0, no frame_err.
REQ-047 Reset recovery: after REQ-046, A5 01 00 01 -> frame_ok.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-parser state encoding, default header byte and baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Clock cycles per bit; the receiver uses the same figure for its bit timer.
  function automatic int cnt_baud_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: expired is a combinational terminal-count strobe, asserted when the
// count would reach LIMIT this cycle; clear has priority, so a byte on the terminal cycle suppresses it.
module uart_timeout_cnt
  import uart_pkg::*;
#(
  parameter int LIMIT = 15600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] r_cnt;

  assign expired = enable && !clear && (r_cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || expired) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HEADER/LEN/PAYLOAD/CHECKSUM frames from a UART byte stream; all outputs registered, 1-cycle latency.
// No backpressure: every pi_flag byte is consumed; payload is streamed out and a frame is judged at its end.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int          clk_frequence = 5_000_000,
  parameter int          baud_rate     = 9600,
  parameter logic [7:0]  HEADER        = HEADER_DEFAULT,
  parameter int          MAX_LEN       = 16,
  parameter int          TIMEOUT_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic [7:0] po_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int         TIMEOUT_LIMIT = TIMEOUT_BYTES * 10 * cnt_baud_max(clk_frequence, baud_rate);
  localparam logic [7:0] MAX_LEN_B     = 8'(MAX_LEN);

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_sum;
  logic [7:0] r_count;
  logic [7:0] r_po_data;
  logic [7:0] r_po_len;
  logic       r_po_flag;
  logic       r_frame_ok;
  logic       r_frame_err;
  logic       r_busy;

  logic       w_to_clear;
  logic       w_to_enable;
  logic       w_expired;

  assign w_to_enable = (r_state != ST_IDLE);
  assign w_to_clear  = pi_flag || (r_state == ST_IDLE);

  uart_timeout_cnt #(
    .LIMIT (TIMEOUT_LIMIT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_to_clear),
    .enable  (w_to_enable),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_po_data   <= '0;
      r_po_len    <= '0;
      r_po_flag   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_po_flag   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      // A byte always takes precedence over a coincident timeout.
      if (pi_flag) begin
        case (r_state)
          ST_IDLE: begin
            if (pi_data == HEADER) begin
              r_state <= ST_LEN;
              r_busy  <= 1'b1;
            end
          end
          ST_LEN: begin
            if ((pi_data == 8'd0) || (pi_data > MAX_LEN_B)) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
            end else begin
              r_len   <= pi_data;
              r_sum   <= pi_data;
              r_count <= '0;
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_po_data <= pi_data;
            r_po_flag <= 1'b1;
            r_sum     <= r_sum + pi_data;
            r_count   <= r_count + 8'd1;
            if ((r_count + 8'd1) == r_len) begin
              r_state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (pi_data == r_sum) begin
              r_frame_ok <= 1'b1;
              r_po_len   <= r_len;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_expired) begin
        r_frame_err <= 1'b1;
        r_state     <= ST_IDLE;
        r_busy      <= 1'b0;
      end
    end
  end

  assign po_data   = r_po_data;
  assign po_flag   = r_po_flag;
  assign po_len    = r_po_len;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized scoreboard bench for uart_frame_parser against a frame-buffer reference model.
module tb_uart_frame_parser;

  localparam int         LIMIT = 3 * 10 * (5_000_000 / 9600);
  localparam logic [7:0] HDR   = 8'hA5;

  localparam int K_PAY = 0;
  localparam int K_OK  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] dat;
    int         edge_n;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] po_data;
  logic       po_flag;
  logic [7:0] po_len;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  ev_t        exp_q[$];
  logic [7:0] fq[$];
  bit         in_frame = 1'b0;
  int         last_e = 0;
  logic [7:0] last_pay = 8'h00;

  uart_frame_parser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .po_len    (po_len),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] dat, input int e);
    ev_t ev;
    ev.kind = kind;
    ev.dat = dat;
    ev.edge_n = e;
    exp_q.push_back(ev);
  endtask

  // Reference model: buffer the bytes after a header and judge the frame from the whole buffer.
  task automatic model_byte(input logic [7:0] b, input int e);
    int         len;
    logic [7:0] s;
    if (!in_frame) begin
      if (b == HDR) begin
        in_frame = 1'b1;
        fq.delete();
        last_e = e;
      end
    end else begin
      fq.push_back(b);
      last_e = e;
      len = int'(fq[0]);
      if (fq.size() == 1) begin
        if (len == 0 || len > 16) begin
          push_ev(K_ERR, 8'h00, e);
          in_frame = 1'b0;
        end
      end else if (fq.size() <= len + 1) begin
        push_ev(K_PAY, b, e);
        last_pay = b;
      end else begin
        s = 8'h00;
        for (int i = 0; i <= len; i++) s = s + fq[i];
        if (s == b) push_ev(K_OK, fq[0], e);
        else        push_ev(K_ERR, 8'h00, e);
        in_frame = 1'b0;
      end
    end
  endtask

  // Called at a negedge; the byte is sampled on the next rising edge.
  task automatic send(input logic [7:0] b);
    model_byte(b, edge_cnt + 1);
    pi_data = b;
    pi_flag = 1'b1;
    @(negedge clk);
    pi_flag = 1'b0;
    chk("busy", 32'(busy), 32'(in_frame));
    chk("po_data_hold", 32'(po_data), 32'(last_pay));
  endtask

  task automatic idle(input int n);
    if (in_frame && n >= LIMIT) begin
      push_ev(K_ERR, 8'h00, last_e + LIMIT);
      in_frame = 1'b0;
    end
    repeat (n) @(negedge clk);
    if (n > 0) chk("busy_idle", 32'(busy), 32'(in_frame));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    pi_data = HDR;
    pi_flag = 1'b1;
    in_frame = 1'b0;
    last_pay = 8'h00;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_po_data", 32'(po_data), 0);
      chk("rst_po_len", 32'(po_len), 0);
      chk("rst_po_flag", 32'(po_flag), 0);
      chk("rst_frame_ok", 32'(frame_ok), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    rst_n = 1'b1;
    pi_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$], input bit corrupt);
    logic [7:0] s;
    s = len;
    send(HDR);
    send(len);
    foreach (pay[i]) begin
      s = s + pay[i];
      send(pay[i]);
    end
    send(corrupt ? s + 8'd1 : s);
  endtask

  task automatic rand_frame();
    int         mode;
    int         len;
    logic [7:0] b;
    logic [7:0] s;
    mode = $urandom_range(0, 9);
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == HDR) b = 8'h5A;
      send(b);
    end
    send(HDR);
    idle($urandom_range(0, 2));
    if (mode == 0) begin
      send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
    end else begin
      len = $urandom_range(1, 16);
      s = 8'(len);
      send(8'(len));
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        s = s + b;
        send(b);
        idle($urandom_range(0, 2));
      end
      send((mode == 1) ? s ^ 8'h40 : s);
    end
    idle($urandom_range(0, 3));
  endtask

  task automatic mon_step();
    ev_t        ev;
    int         k;
    logic [7:0] d;
    if (po_flag || frame_ok || frame_err) begin
      checks++;
      k = po_flag ? K_PAY : (frame_ok ? K_OK : K_ERR);
      d = po_flag ? po_data : (frame_ok ? po_len : 8'h00);
      if (frame_ok && frame_err) begin
        errors++;
        $display("FAIL ok_err_exclusive got=both_high exp=at_most_one edge=%0d", edge_cnt);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got kind=%0d dat=%02h edge=%0d exp=no_event", k, d, edge_cnt);
      end else begin
        ev = exp_q.pop_front();
        if (ev.kind != k || ev.dat != d || ev.edge_n != edge_cnt) begin
          errors++;
          $display("FAIL sb_event got kind=%0d dat=%02h edge=%0d exp kind=%0d dat=%02h edge=%0d",
                   k, d, edge_cnt, ev.kind, ev.dat, ev.edge_n);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] p[$];
    rst_n = 1'b0;
    pi_data = 8'h00;
    pi_flag = 1'b0;
    @(negedge clk);
    do_reset(2);
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    p = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, p, 1'b0);
    send_frame(8'h03, p, 1'b1);
    send(8'h00); send(8'hFF); send(HDR); send(8'h00);
    send(HDR); send(8'h01); send(8'h7E); send(8'h7F);
    send(HDR); send(8'h11);
    p = '{8'hA5, 8'hA5};
    send_frame(8'h02, p, 1'b0);
    p = '{};
    for (int i = 0; i < 16; i++) p.push_back(8'(i * 17 + 3));
    send_frame(8'd16, p, 1'b0);
    idle(2);

    repeat (40) rand_frame();

    send(HDR); send(8'h03); send(8'h11);
    idle(LIMIT + 3);
    send(HDR); send(8'h03); send(8'h11);
    idle(LIMIT - 1);
    send(8'h22); send(8'h33); send(8'h69);
    idle(2);

    send(HDR); send(8'h03); send(8'h11);
    do_reset(2);
    send(HDR); send(8'h01); send(8'h00); send(8'h01);

    repeat (10) rand_frame();
    idle(5);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
